// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// ROM request/response, redirect and decoder-side signals of the fetch stage.
// instr_misalign exists only when FETCH_MISALIGN_EN is defined.
interface fetch_if;
  import fetch_pkg::*;

  logic            rom_read;
  logic [XLEN-1:0] rom_addr;
  logic            rom_ready;
  logic            rom_valid;
  logic [XLEN-1:0] rom_readdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
`ifdef FETCH_MISALIGN_EN
  logic            instr_misalign;
`endif

  modport master (
    output rom_read, rom_addr,
    input  rom_ready, rom_valid, rom_readdata,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
`ifdef FETCH_MISALIGN_EN
    , output instr_misalign
`endif
  );

  modport slave (
    input  rom_read, rom_addr,
    output rom_ready, rom_valid, rom_readdata,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
`ifdef FETCH_MISALIGN_EN
    , input instr_misalign
`endif
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of tagged fetch entries with a flush that empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited ROM requests, in-order response buffering and redirect squash.
// Optional misaligned-redirect trap entry is enabled by defining FETCH_MISALIGN_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] resp_pc_reg;
  logic [CW-1:0]   inflight_reg;
  logic [CW-1:0]   drop_cnt_reg;
  logic            halted_reg;
  logic            nop_pend_reg;

  logic [XLEN-1:0] target_pc;
  logic            target_bad;
  logic [CW-1:0]   count;
  logic [CW-1:0]   credit_used;
  logic [CW-1:0]   inflight_left;
  logic            req;
  logic            accept;
  logic            resp_fire;
  logic            push_resp;
  logic            push_nop;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_EN
  assign target_pc  = bus.redirect_pc;
  assign target_bad = |bus.redirect_pc[1:0];
`else
  logic lsb_unused;
  assign target_pc  = word_align(bus.redirect_pc);
  assign target_bad = 1'b0;
  assign lsb_unused = (^bus.redirect_pc[1:0]) ^ head.misalign;
`endif

  // Every buffer slot is reserved at request time, so the FIFO can never overflow.
  assign credit_used   = inflight_reg + count;
  assign req           = !reset && !bus.redirect && !halted_reg && (credit_used < DEPTH_C);
  assign accept        = req && bus.rom_ready;
  assign resp_fire     = bus.rom_valid && (inflight_reg != '0);
  assign inflight_left = inflight_reg - CW'(resp_fire);

  assign push_resp = resp_fire && (drop_cnt_reg == '0) && !bus.redirect;
  assign push_nop  = nop_pend_reg && (drop_cnt_reg == '0) && !bus.redirect;
  assign push      = push_resp || push_nop;
  assign pop       = (count != '0) && bus.instr_ready;

  always_comb begin
    push_data.pc = resp_pc_reg;
    if (push_nop) begin
      push_data.instr    = INSTR_NOP;
      push_data.misalign = 1'b1;
    end else begin
      push_data.instr    = bus.rom_readdata;
      push_data.misalign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= word_align(RESET_PC);
      resp_pc_reg  <= word_align(RESET_PC);
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
      halted_reg   <= 1'b0;
      nop_pend_reg <= 1'b0;
    end else if (bus.redirect) begin
      // A response arriving in the redirect cycle is discarded along with the rest.
      fetch_pc_reg <= word_align(target_pc);
      resp_pc_reg  <= target_pc;
      inflight_reg <= inflight_left;
      drop_cnt_reg <= inflight_left;
      halted_reg   <= target_bad;
      nop_pend_reg <= target_bad;
    end else begin
      if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
      inflight_reg <= inflight_left + CW'(accept);
      if (resp_fire && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - CW'(1);
      if (push_resp) resp_pc_reg <= resp_pc_reg + 32'd4;
      if (push_nop) nop_pend_reg <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count)
  );

  assign bus.rom_read    = req;
  assign bus.rom_addr    = fetch_pc_reg;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
`ifdef FETCH_MISALIGN_EN
  assign bus.instr_misalign = head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit killed; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; bit mis; } ent_t;
  typedef struct { logic [31:0] addr; int due; } rom_t;
  typedef struct { int cyc; logic [31:0] addr; } acc_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] instr; bit mis; } pop_t;

  // Model: requests in flight (tagged dead when a redirect overtakes them) and the expected buffer.
  req_t        m_infl[$];
  ent_t        m_buf[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pend_pc;
  bit          m_halted;
  bit          m_pend;
  bit          live;

  rom_t rom_q[$];
  int   rom_last_due;
  acc_t acc_log[$];
  pop_t pop_log[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          t_reset, t_redirect, t_rom_ready, t_instr_ready, t_lat_rand;
  logic [31:0] t_redirect_pc;
  int          t_lat;
  bit          s_rom_read, s_instr_valid;
  logic [31:0] s_instr_pc;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] acc_addr(input int i);
    return (i < acc_log.size()) ? acc_log[i].addr : 32'hxxxx_xxxx;
  endfunction
  function automatic int acc_cyc(input int i);
    return (i < acc_log.size()) ? acc_log[i].cyc : -1;
  endfunction
  function automatic logic [31:0] pop_pc(input int i);
    return (i < pop_log.size()) ? pop_log[i].pc : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] pop_instr(input int i);
    return (i < pop_log.size()) ? pop_log[i].instr : 32'hxxxx_xxxx;
  endfunction
  function automatic int pop_cyc(input int i);
    return (i < pop_log.size()) ? pop_log[i].cyc : -1;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model, wait for the edge.
  task automatic step();
    bit   exp_rr;
    bit   resp;
    bit   infl_empty;
    req_t r;
    ent_t e;
    acc_t a;
    pop_t p;
    rom_t q;
    int   due;
    #2;
    reset           = t_reset;
    bus.redirect    = t_redirect;
    bus.redirect_pc = t_redirect_pc;
    bus.rom_ready   = t_rom_ready;
    bus.instr_ready = t_instr_ready;
    if (rom_q.size() != 0 && rom_q[0].due <= cyc) begin
      bus.rom_valid    = 1'b1;
      bus.rom_readdata = rom_word(rom_q[0].addr);
      void'(rom_q.pop_front());
    end else begin
      bus.rom_valid    = 1'b0;
      bus.rom_readdata = $urandom;
    end
    #2;
    exp_rr = !t_reset && !t_redirect && !m_halted && ((m_infl.size() + m_buf.size()) < DEPTH);
    if (live) begin
      chk1("rom_read", bus.rom_read, exp_rr);
      if (exp_rr && bus.rom_read) chk("rom_addr", bus.rom_addr, m_fetch_pc);
      chk1("instr_valid", bus.instr_valid, m_buf.size() != 0);
      if (m_buf.size() != 0 && bus.instr_valid) begin
        chk("instr", bus.instr, m_buf[0].instr);
        chk("instr_pc", bus.instr_pc, m_buf[0].pc);
`ifdef FETCH_MISALIGN_EN
        chk1("instr_misalign", bus.instr_misalign, m_buf[0].mis);
`endif
      end
    end
    s_rom_read    = bus.rom_read;
    s_instr_valid = bus.instr_valid;
    s_instr_pc    = bus.instr_pc;
    if (bus.rom_read && bus.rom_ready) begin
      a.cyc  = cyc;
      a.addr = bus.rom_addr;
      acc_log.push_back(a);
      due = cyc + (t_lat_rand ? int'($urandom_range(1, 4)) : t_lat);
      if (due <= rom_last_due) due = rom_last_due + 1;
      rom_last_due = due;
      q.addr = bus.rom_addr;
      q.due  = due;
      rom_q.push_back(q);
    end
    if (bus.instr_valid && bus.instr_ready) begin
      p.cyc   = cyc;
      p.pc    = bus.instr_pc;
      p.instr = bus.instr;
`ifdef FETCH_MISALIGN_EN
      p.mis   = bus.instr_misalign;
`else
      p.mis   = 1'b0;
`endif
      pop_log.push_back(p);
    end
    if (t_reset) begin
      m_infl.delete();
      m_buf.delete();
      rom_q.delete();
      rom_last_due = 0;
      m_fetch_pc   = RESET_PC;
      m_halted     = 1'b0;
      m_pend       = 1'b0;
      live         = 1'b1;
    end else begin
      resp       = bus.rom_valid && (m_infl.size() != 0);
      infl_empty = (m_infl.size() == 0);
      r.addr     = '0;
      r.killed   = 1'b1;
      if (resp) r = m_infl.pop_front();
      if (t_redirect) begin
        m_buf.delete();
        foreach (m_infl[i]) m_infl[i].killed = 1'b1;
        m_halted   = MIS_EN && (t_redirect_pc[1:0] != 2'b00);
        m_pend     = m_halted;
        m_pend_pc  = t_redirect_pc;
        m_fetch_pc = {t_redirect_pc[31:2], 2'b00};
      end else begin
        if (t_instr_ready && m_buf.size() != 0) void'(m_buf.pop_front());
        if (resp && !r.killed) begin
          e.instr = rom_word(r.addr);
          e.pc    = r.addr;
          e.mis   = 1'b0;
          m_buf.push_back(e);
        end
        if (m_pend && infl_empty) begin
          e.instr = INSTR_NOP;
          e.pc    = m_pend_pc;
          e.mis   = 1'b1;
          m_buf.push_back(e);
          m_pend  = 1'b0;
        end
        if (exp_rr && t_rom_ready) begin
          r.addr   = m_fetch_pc;
          r.killed = 1'b0;
          m_infl.push_back(r);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    t_reset    = 1'b1;
    t_redirect = 1'b0;
    run(2);
    #1;
    chk1("reset instr_valid", bus.instr_valid, 1'b0);
    chk("reset instr", bus.instr, 32'h0);
    chk("reset instr_pc", bus.instr_pc, 32'h0);
    chk1("reset rom_read", bus.rom_read, 1'b0);
`ifdef FETCH_MISALIGN_EN
    chk1("reset instr_misalign", bus.instr_misalign, 1'b0);
`endif
    t_reset = 1'b0;
    acc_log.delete();
    pop_log.delete();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    t_redirect    = 1'b1;
    t_redirect_pc = pc;
    run(1);
    t_redirect = 1'b0;
    acc_log.delete();
    pop_log.delete();
  endtask

  initial begin
    int c0;
    reset            = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.rom_ready    = 1'b0;
    bus.rom_valid    = 1'b0;
    bus.rom_readdata = '0;
    bus.instr_ready  = 1'b0;
    t_redirect_pc    = '0;
    t_rom_ready      = 1'b1;
    t_instr_ready    = 1'b1;
    t_lat            = 1;
    t_lat_rand       = 1'b0;
    live             = 1'b0;
    rom_last_due     = 0;
    @(posedge clk);

    // Streaming with a 1-cycle ROM.
    do_reset();
    c0 = cyc;
    run(12);
    chk("first_req_cycle", 32'(acc_cyc(0)), 32'(c0));
    chk("req0", acc_addr(0), 32'h0);
    chk("req1", acc_addr(1), 32'h4);
    chk("req2", acc_addr(2), 32'h8);
    for (int i = 0; i < 3; i++) begin
      chk("stream_pc", pop_pc(i), 32'(4 * i));
      chk("stream_cycle", 32'(pop_cyc(i)), 32'(c0 + 2 + i));
    end
    $display("phase stream: checks %0d", checks);

    // Consumer stalled: credit limits requests to DEPTH.
    do_reset();
    t_instr_ready = 1'b0;
    run(12);
    chk("stall_accepts", 32'(acc_log.size()), 32'(DEPTH));
    chk("stall_head_pc", s_instr_pc, 32'h0);
    chk1("stall_rom_read", s_rom_read, 1'b0);
    pop_log.delete();
    t_instr_ready = 1'b1;
    c0 = cyc;
    run(6);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", pop_pc(i), 32'(4 * i));
      chk("drain_cycle", 32'(pop_cyc(i)), 32'(c0 + i));
    end
    $display("phase stall: checks %0d", checks);

    // Redirect with two reads in flight on a 3-cycle ROM.
    do_reset();
    t_lat = 3;
    run(2);
    t_rom_ready = 1'b0;
    redirect_to(32'h0000_0200);
    chk1("redir_cycle_rom_read", s_rom_read, 1'b0);
    t_rom_ready = 1'b1;
    c0 = cyc;
    run(1);
    chk("post_redir_req", acc_addr(0), 32'h0000_0200);
    chk("post_redir_req_cycle", 32'(acc_cyc(0)), 32'(c0));
    chk1("post_redir_valid", s_instr_valid, 1'b0);
    run(10);
    chk("post_redir_pc", pop_pc(0), 32'h0000_0200);
    chk("post_redir_instr", pop_instr(0), rom_word(32'h0000_0200));
    $display("phase redirect_inflight: checks %0d", checks);

    // Redirect coinciding with a response and a pop.
    do_reset();
    t_lat = 1;
    run(6);
    redirect_to(32'h0000_0300);
    chk1("coinc_head_valid", s_instr_valid, 1'b1);
    run(1);
    chk1("coinc_flushed", s_instr_valid, 1'b0);
    run(8);
    chk("coinc_next_pc", pop_pc(0), 32'h0000_0300);
    $display("phase redirect_coincident: checks %0d", checks);

    // Address wrap at the top of the address space.
    do_reset();
    redirect_to(32'hFFFF_FFF8);
    run(10);
    chk("wrap_req0", acc_addr(0), 32'hFFFF_FFF8);
    chk("wrap_req1", acc_addr(1), 32'hFFFF_FFFC);
    chk("wrap_req2", acc_addr(2), 32'h0000_0000);
    chk("wrap_pop2", pop_pc(2), 32'h0000_0000);
    $display("phase wrap: checks %0d", checks);

    // Misaligned redirect target.
    do_reset();
`ifdef FETCH_MISALIGN_EN
    redirect_to(32'h0000_0102);
    run(10);
    chk("halt_accepts", 32'(acc_log.size()), 32'h0);
    chk("halt_pops", 32'(pop_log.size()), 32'h1);
    chk("halt_pc", pop_pc(0), 32'h0000_0102);
    chk("halt_instr", pop_instr(0), 32'h0000_0013);
    chk1("halt_misalign", (pop_log.size() != 0) && pop_log[0].mis, 1'b1);
    redirect_to(32'h0000_0100);
    run(5);
    chk("resume_req", acc_addr(0), 32'h0000_0100);
`else
    redirect_to(32'h0000_0106);
    run(8);
    chk("align_req", acc_addr(0), 32'h0000_0104);
    chk("align_pop", pop_pc(0), 32'h0000_0104);
`endif
    $display("phase misalign: checks %0d", checks);

    // Randomized traffic.
    t_lat_rand = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      t_reset       = ($urandom_range(0, 499) == 0);
      t_redirect    = ($urandom_range(0, 29) == 0);
      t_rom_ready   = ($urandom_range(0, 9) < 7);
      t_instr_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       t_redirect_pc = $urandom & 32'hFFFF_FFFC;
        1:       t_redirect_pc = 32'($urandom_range(0, 63)) << 2;
        2:       t_redirect_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        default: t_redirect_pc = 32'h0000_0100;
      endcase
      if ($urandom_range(0, 7) == 0) t_redirect_pc[1:0] = 2'($urandom_range(1, 3));
      step();
    end
    $display("phase random: checks %0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
